// File: rtl/bpred_tracker.sv
// bpred_tracker: tracks in-flight branch predictions in order, drives the
// 1-bit prediction table's update port on resolve, and flushes wrong-path
// entries when the oldest branch turns out to be mispredicted.
module bpred_tracker #(
  parameter int unsigned PCWIDTH   = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG2DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 predict,
  input  logic [PCWIDTH-1:0]   predict_pc,
  input  logic                 prediction,
  input  logic                 resolve,
  input  logic                 resolve_taken,
  input  logic                 flush,
  output logic                 result_rdy,
  output logic                 result,
  output logic [PCWIDTH-1:0]   pc_result,
  output logic                 mispredict,
  output logic                 mispredict_taken,
  output logic                 full,
  output logic                 empty,
  output logic [LOG2DEPTH:0]   count,
  output logic                 err
);

  localparam int unsigned CW = LOG2DEPTH + 1;
  localparam int unsigned PW = LOG2DEPTH;

  // FIFO storage and capture stage
  logic [PCWIDTH-1:0] fifo_pc [DEPTH];
  logic [DEPTH-1:0]   fifo_pred;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               pend_valid;
  logic [PCWIDTH-1:0] pend_pc;

  // Per-cycle control decisions
  logic [CW:0]        occ_c;
  logic               head_pred_c;
  logic [PCWIDTH-1:0] head_pc_c;
  logic               resolve_ok_c;
  logic               mis_c;
  logic               kill_c;
  logic               push_c;
  logic               pop_c;
  logic               capture_c;
  logic               err_set_c;

  // Decode this cycle's push/pop/capture/mispredict from registered state
  always_comb begin
    occ_c        = {1'b0, count} + (CW+1)'(pend_valid);
    full         = occ_c >= (CW+1)'(DEPTH);
    empty        = (count == CW'(0)) && !pend_valid;
    head_pred_c  = fifo_pred[rd_ptr];
    head_pc_c    = fifo_pc[rd_ptr];
    resolve_ok_c = resolve && !flush && (count != CW'(0));
    mis_c        = resolve_ok_c && (head_pred_c != resolve_taken);
    kill_c       = flush || mis_c;
    push_c       = pend_valid && !kill_c;
    pop_c        = resolve_ok_c && !mis_c;
    capture_c    = predict && !full && !kill_c;
    err_set_c    = !flush && ((predict && full) || (resolve && (count == CW'(0))));
  end

  // FIFO payload write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_pc[wr_ptr]   <= pend_pc;
      fifo_pred[wr_ptr] <= prediction;
    end
  end

  // Control state, pointers, table update port and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      pend_valid       <= 1'b0;
      pend_pc          <= '0;
      result_rdy       <= 1'b0;
      result           <= 1'b0;
      pc_result        <= '0;
      mispredict       <= 1'b0;
      mispredict_taken <= 1'b0;
      err              <= 1'b0;
    end else begin
      pend_valid <= capture_c;
      if (capture_c) begin
        pend_pc <= predict_pc;
      end

      if (kill_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push_c && !pop_c) begin
          count <= count + CW'(1);
        end else if (pop_c && !push_c) begin
          count <= count - CW'(1);
        end
      end

      result_rdy <= resolve_ok_c;
      if (resolve_ok_c) begin
        result    <= resolve_taken;
        pc_result <= head_pc_c;
      end

      mispredict <= mis_c;
      if (mis_c) begin
        mispredict_taken <= resolve_taken;
      end

      if (err_set_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpred_tracker.sv
// Directed, table-driven bench for bpred_tracker.
module tb_bpred_tracker;

  localparam int unsigned PCW = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           predict = 1'b0;
  logic [PCW-1:0] predict_pc = '0;
  logic           prediction = 1'b0;
  logic           resolve = 1'b0;
  logic           resolve_taken = 1'b0;
  logic           flush = 1'b0;
  logic           result_rdy;
  logic           result;
  logic [PCW-1:0] pc_result;
  logic           mispredict;
  logic           mispredict_taken;
  logic           full;
  logic           empty;
  logic [2:0]     count;
  logic           err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bpred_tracker #(.PCWIDTH(PCW), .DEPTH(4), .LOG2DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .predict          (predict),
    .predict_pc       (predict_pc),
    .prediction       (prediction),
    .resolve          (resolve),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .result_rdy       (result_rdy),
    .result           (result),
    .pc_result        (pc_result),
    .mispredict       (mispredict),
    .mispredict_taken (mispredict_taken),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .err              (err)
  );

  typedef struct {
    logic           rst, pr;
    logic [PCW-1:0] ppc;
    logic           pn, rs, tk, fl;
    logic [2:0]     cnt;
    logic           rdy, res;
    logic [PCW-1:0] pcr;
    logic           mis, mtk, full, empty, err;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, pr, input logic [PCW-1:0] ppc,
                              input logic pn, rs, tk, fl,
                              input logic [2:0] cnt, input logic rdy, res,
                              input logic [PCW-1:0] pcr,
                              input logic mis, mtk, fu, em, er);
    vec_t v;
    v.rst = rst; v.pr = pr; v.ppc = ppc; v.pn = pn; v.rs = rs; v.tk = tk; v.fl = fl;
    v.cnt = cnt; v.rdy = rdy; v.res = res; v.pcr = pcr;
    v.mis = mis; v.mtk = mtk; v.full = fu; v.empty = em; v.err = er;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, then compare all outputs 1ns after the edge
  task automatic apply(input string name, input vec_t v);
    logic [41:0] act, exp;
    reset = v.rst; predict = v.pr; predict_pc = v.ppc; prediction = v.pn;
    resolve = v.rs; resolve_taken = v.tk; flush = v.fl;
    @(posedge clk);
    #1;
    act = {count, result_rdy, result, pc_result, mispredict, mispredict_taken, full, empty, err};
    exp = {v.cnt, v.rdy, v.res, v.pcr, v.mis, v.mtk, v.full, v.empty, v.err};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d rdy=%b res=%b pcr=%h mis=%b mtk=%b full=%b empty=%b err=%b; want cnt=%0d rdy=%b res=%b pcr=%h mis=%b mtk=%b full=%b empty=%b err=%b",
               name, count, result_rdy, result, pc_result, mispredict, mispredict_taken, full, empty, err,
               v.cnt, v.rdy, v.res, v.pcr, v.mis, v.mtk, v.full, v.empty, v.err);
    end
  endtask

  initial begin
    //            rst pr ppc      pn rs tk fl | cnt rdy res pcr      mis mtk full empty err
    // single branch, correct taken prediction
    vecs[0]  = mk(1, 0, 32'h000, 0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 1, 32'h100, 0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h000, 1, 0, 0, 0,  1, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h000, 0, 0, 0, 0,  1, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h000, 0, 1, 1, 0,  0, 1, 1, 32'h100, 0, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 32'h000, 0, 0, 0, 0,  0, 0, 1, 32'h100, 0, 0, 0, 1, 0);
    // mispredict flush of three in-flight branches, then resolve on empty
    vecs[6]  = mk(0, 1, 32'h010, 0, 0, 0, 0,  0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 32'h020, 0, 0, 0, 0,  1, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h030, 1, 0, 0, 0,  2, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 32'h000, 1, 0, 0, 0,  3, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h000, 0, 1, 1, 0,  0, 1, 1, 32'h010, 1, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 32'h000, 0, 1, 0, 0,  0, 0, 1, 32'h010, 0, 1, 0, 1, 1);
    // fill to full, overflow attempt, then steady push/pop across pointer wrap
    vecs[12] = mk(1, 0, 32'h000, 0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 1, 32'h200, 0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 32'h204, 1, 0, 0, 0,  1, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 32'h208, 1, 0, 0, 0,  2, 0, 0, 32'h000, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 32'h20c, 1, 0, 0, 0,  3, 0, 0, 32'h000, 0, 0, 1, 0, 0);
    vecs[17] = mk(0, 1, 32'h210, 1, 0, 0, 0,  4, 0, 0, 32'h000, 0, 0, 1, 0, 1);
    vecs[18] = mk(0, 0, 32'h000, 0, 0, 0, 0,  4, 0, 0, 32'h000, 0, 0, 1, 0, 1);
    vecs[19] = mk(0, 0, 32'h000, 0, 1, 1, 0,  3, 1, 1, 32'h200, 0, 0, 0, 0, 1);
    vecs[20] = mk(0, 1, 32'h300, 0, 1, 1, 0,  2, 1, 1, 32'h204, 0, 0, 0, 0, 1);
    vecs[21] = mk(0, 1, 32'h304, 1, 1, 1, 0,  2, 1, 1, 32'h208, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 1, 32'h308, 1, 1, 1, 0,  2, 1, 1, 32'h20c, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 1, 32'h30c, 1, 1, 1, 0,  2, 1, 1, 32'h300, 0, 0, 0, 0, 1);
    vecs[24] = mk(0, 0, 32'h000, 1, 1, 1, 0,  2, 1, 1, 32'h304, 0, 0, 0, 0, 1);
    // flush together with a would-be mispredicting resolve and a pending capture
    vecs[25] = mk(0, 1, 32'h400, 0, 0, 0, 0,  2, 0, 1, 32'h304, 0, 0, 0, 0, 1);
    vecs[26] = mk(0, 0, 32'h000, 1, 1, 0, 1,  0, 0, 1, 32'h304, 0, 0, 0, 1, 1);
    vecs[27] = mk(0, 0, 32'h000, 0, 0, 0, 0,  0, 0, 1, 32'h304, 0, 0, 0, 1, 1);
    // reset with count=3 and a pending capture
    vecs[28] = mk(0, 1, 32'h500, 0, 0, 0, 0,  0, 0, 1, 32'h304, 0, 0, 0, 0, 1);
    vecs[29] = mk(0, 1, 32'h504, 0, 0, 0, 0,  1, 0, 1, 32'h304, 0, 0, 0, 0, 1);
    vecs[30] = mk(0, 1, 32'h508, 1, 0, 0, 0,  2, 0, 1, 32'h304, 0, 0, 0, 0, 1);
    vecs[31] = mk(0, 1, 32'h50c, 0, 0, 0, 0,  3, 0, 1, 32'h304, 0, 0, 1, 0, 1);
    vecs[32] = mk(1, 0, 32'h000, 1, 1, 1, 0,  0, 0, 0, 32'h000, 0, 0, 0, 1, 0);
    vecs[33] = mk(0, 0, 32'h000, 0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0, 1, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply($sformatf("vec[%0d]", i), vecs[i]);
    end

    // Mispredict while a push and a new capture are in flight: both are dropped
    apply("mis_seq_cap",   mk(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 32'h000, 0, 0, 0, 0, 0));
    apply("mis_seq_push",  mk(0, 1, 32'h604, 0, 0, 0, 0, 1, 0, 0, 32'h000, 0, 0, 0, 0, 0));
    apply("mis_seq_kill",  mk(0, 1, 32'h608, 1, 1, 1, 0, 0, 1, 1, 32'h600, 1, 1, 0, 1, 0));
    apply("mis_seq_after", mk(0, 0, 32'h000, 0, 0, 0, 0, 0, 0, 1, 32'h600, 0, 1, 0, 1, 0));

    // Flush leaves err untouched even with a resolve on an empty FIFO
    apply("flush_err_keep", mk(0, 0, 32'h000, 0, 1, 0, 1, 0, 0, 1, 32'h600, 0, 1, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
